// File: rtl/crc_ccitt_pkg.sv
// Shared constants for the CRC-16/CCITT-FALSE byte-serial engine.
package crc_ccitt_pkg;

    localparam logic [15:0] CRC_POLY            = 16'h1021;
    localparam logic [15:0] CRC_SEED            = 16'hFFFF;
    localparam logic [15:0] CRC_CHECK_123456789 = 16'h29B1;
    localparam logic [15:0] CRC_CHECK_00        = 16'hE1F0;

endpackage

// File: rtl/crc_ccitt_byte_next.sv
// Combinational CRC update for one message byte, MSB first, unrolled over 8 bit steps.
module crc_ccitt_byte_next
    import crc_ccitt_pkg::*;
#(
    parameter logic [15:0] POLY = CRC_POLY
) (
    input  logic [15:0] crc_in,
    input  logic [7:0]  data,
    output logic [15:0] crc_next
);

    logic [15:0] crc_w;
    logic        fb;

    always_comb begin
        crc_w = crc_in;
        fb    = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            fb    = crc_w[15] ^ data[i];
            crc_w = {crc_w[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);
        end
        crc_next = crc_w;
    end

endmodule

// File: rtl/serial_crc_ccitt.sv
// CRC-16/CCITT register that absorbs one byte per cycle; init restarts from SEED.
module serial_crc_ccitt
    import crc_ccitt_pkg::*;
#(
    parameter logic [15:0] POLY = CRC_POLY,
    parameter logic [15:0] SEED = CRC_SEED
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        init,
    input  logic [7:0]  data_in,
    output logic [15:0] crc_out
);

    logic [15:0] crc_q;
    logic [15:0] crc_d;
    logic [15:0] crc_base;
    logic [15:0] crc_next;

    // init with enable starts a fresh message on this very byte.
    assign crc_base = init ? SEED : crc_q;

    crc_ccitt_byte_next #(
        .POLY(POLY)
    ) u_byte_next (
        .crc_in  (crc_base),
        .data    (data_in),
        .crc_next(crc_next)
    );

    always_comb begin
        crc_d = crc_q;
        if (enable) begin
            crc_d = crc_next;
        end else if (init) begin
            crc_d = SEED;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            crc_q <= SEED;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_out = crc_q;

endmodule

// File: tb/tb_serial_crc_ccitt.sv
// Scoreboard bench: driver queues the expected crc for each driven cycle, monitor checks it.
module tb_serial_crc_ccitt;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        init;
    logic [7:0]  data_in;
    logic [15:0] crc_out;

    typedef struct {
        logic [15:0] exp;
        string       name;
    } sb_entry_t;

    sb_entry_t   sb_q[$];
    int          n_pass  = 0;
    int          n_total = 0;
    logic [15:0] model   = 16'hFFFF;
    logic [7:0]  msg[9]  = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

    always #5 clk = ~clk;

    serial_crc_ccitt dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .init   (init),
        .data_in(data_in),
        .crc_out(crc_out)
    );

    // Bitwise reference, one message bit at a time.
    function automatic logic [15:0] ref_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            if (r[15] != d[i]) r = (r << 1) ^ 16'h1021;
            else               r = r << 1;
        end
        return r;
    endfunction

    // Drive one cycle; expected value is the hand constant k when has_k, else the model.
    task automatic step(input logic rst, input logic en, input logic ini, input logic [7:0] d,
                        input logic has_k, input logic [15:0] k, input string name);
        sb_entry_t e;
        @(negedge clk);
        reset   = rst;
        enable  = en;
        init    = ini;
        data_in = d;
        if (rst)      model = 16'hFFFF;
        else if (ini) model = en ? ref_byte(16'hFFFF, d) : 16'hFFFF;
        else if (en)  model = ref_byte(model, d);
        if (has_k) model = k;
        e.exp  = model;
        e.name = name;
        sb_q.push_back(e);
    endtask

    task automatic idle_x(input string name);
        @(negedge clk);
        reset   = 1'b0;
        enable  = 1'b0;
        init    = 1'b0;
        data_in = 8'bx;
        begin
            sb_entry_t e;
            e.exp  = model;
            e.name = name;
            sb_q.push_back(e);
        end
    endtask

    // Monitor: each driven cycle is presented on the following rising edge.
    initial begin
        sb_entry_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_total++;
                if (crc_out === e.exp) n_pass++;
                else $display("FAIL %s: crc_out=%h expected=%h", e.name, crc_out, e.exp);
            end
        end
    end

    initial begin
        reset   = 1'b0;
        enable  = 1'b0;
        init    = 1'b0;
        data_in = 8'h00;

        step(1, 1, 1, 8'h55, 1, 16'hFFFF, "reset");
        for (int i = 0; i < 5; i++) step(0, 0, 0, 8'hA5, 1, 16'hFFFF, "idle_hold");

        step(0, 1, 0, 8'h00, 1, 16'hE1F0, "byte_00");
        step(1, 0, 0, 8'h00, 1, 16'hFFFF, "reset2");
        step(0, 1, 0, 8'h41, 1, 16'hB915, "byte_41");

        step(1, 0, 0, 8'h00, 1, 16'hFFFF, "reset3");
        for (int i = 0; i < 8; i++) step(0, 1, 0, msg[i], 0, 16'h0, "check_str");
        step(0, 1, 0, msg[8], 1, 16'h29B1, "check_29b1");

        for (int i = 0; i < 4; i++) step(0, 1, 0, msg[i], 0, 16'h0, "partial");
        step(0, 1, 1, 8'h00, 1, 16'hE1F0, "init_en_00");
        step(0, 1, 0, 8'h77, 0, 16'h0, "after_init");
        step(0, 0, 1, 8'h77, 1, 16'hFFFF, "init_alone");
        step(0, 1, 0, 8'h31, 0, 16'h0, "partial2");
        step(1, 1, 1, 8'h31, 1, 16'hFFFF, "reset_priority");

        for (int i = 0; i < 9; i++) begin
            int gaps;
            gaps = $urandom_range(0, 3);
            for (int g = 0; g < gaps; g++) idle_x("gap_hold");
            if (i < 8) step(0, 1, 0, msg[i], 0, 16'h0, "gap_str");
            else       step(0, 1, 0, msg[i], 1, 16'h29B1, "gap_29b1");
        end

        step(1, 0, 0, 8'h00, 1, 16'hFFFF, "reset4");
        for (int i = 0; i < 30; i++) begin
            logic [7:0] b;
            b = 8'($urandom_range(0, 255));
            if (i == 15) step(1, 1, 0, b, 1, 16'hFFFF, "rand_reset");
            else         step(0, 1, 0, b, 0, 16'h0, "rand_byte");
        end

        for (int t = 0; t < 10 && sb_q.size() > 0; t++) @(posedge clk);
        #2;
        if (sb_q.size() > 0) begin
            n_total++;
            $display("FAIL drain: pending=%0d expected=0", sb_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
